// File: rtl/fifo_fwft_pkg.sv
// Shared constants, FSM encoding and width helpers for the FWFT FIFO.
package fifo_fwft_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

  // Output register occupancy; the state bit doubles as pop_valid_o.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Pointer width for the backing memory of a FIFO of the given total depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

  // Width needed to hold a count from 0 to depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_fwft_mem_1r1w.sv
// Storage array: synchronous write, asynchronous read, no reset.
module fifo_mem_1r1w
  import fifo_fwft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_FIFO_DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [ptr_width(DEPTH+1)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [ptr_width(DEPTH+1)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]         rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; a same-cycle read of this entry still sees the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: registered head word plus a DEPTH-1 entry memory.
module fifo_fwft
  import fifo_fwft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned AF_THR     = FIFO_DEPTH - 1,
  parameter int unsigned AE_THR     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic [DATA_WIDTH-1:0]            push_data_i,
  input  logic                             push_valid_i,
  output logic                             push_grant_o,
  output logic [DATA_WIDTH-1:0]            pop_data_o,
  output logic                             pop_valid_o,
  input  logic                             pop_grant_i,
  output logic [cnt_width(FIFO_DEPTH)-1:0] count_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o
);

  localparam int unsigned MEM_DEPTH = FIFO_DEPTH - 1;
  localparam int unsigned PTR_W     = ptr_width(FIFO_DEPTH);
  localparam int unsigned CNT_W     = cnt_width(FIFO_DEPTH);

  // Reject illegal configurations at elaboration.
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fifo_fwft: FIFO_DEPTH must be >= 2");
  end
  if (AF_THR < 1 || AF_THR > FIFO_DEPTH) begin : g_bad_af
    $error("fifo_fwft: AF_THR out of range 1..FIFO_DEPTH");
  end
  if (AE_THR > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("fifo_fwft: AE_THR out of range 0..FIFO_DEPTH-1");
  end

  out_state_e            out_state_q, out_state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_ld;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [CNT_W-1:0]      mem_count;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  out_upd;

  // Handshake and flag decode from registered state only.
  assign pop_valid_o    = (out_state_q == OUT_VALID);
  assign push_grant_o   = rst_n & (count_q < CNT_W'(FIFO_DEPTH));
  assign pop_data_o     = data_q;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= CNT_W'(AF_THR));
  assign almost_empty_o = (count_q <= CNT_W'(AE_THR));

  assign push_acc  = push_valid_i & push_grant_o;
  assign pop_acc   = pop_valid_o & pop_grant_i;
  assign mem_count = count_q - CNT_W'(pop_valid_o);
  assign out_upd   = pop_acc | ~pop_valid_o;

  // Pointer increment with explicit wrap for non-power-of-2 memories.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= OUT_EMPTY;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      data_q      <= '0;
    end else begin
      out_state_q <= out_state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      if (data_ld) begin
        data_q <= data_d;
      end
    end
  end

  // Next-state: refill/bypass the output register, write memory, track count.
  always_comb begin
    out_state_d = out_state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    data_d      = data_q;
    data_ld     = 1'b0;
    mem_we      = 1'b0;

    if (flush_i) begin
      out_state_d = OUT_EMPTY;
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
    end else begin
      if (out_upd) begin
        if (mem_count != '0) begin
          data_d      = mem_rdata;
          data_ld     = 1'b1;
          rd_ptr_d    = ptr_inc(rd_ptr_q);
          out_state_d = OUT_VALID;
        end else if (push_acc) begin
          data_d      = push_data_i;
          data_ld     = 1'b1;
          out_state_d = OUT_VALID;
        end else begin
          out_state_d = OUT_EMPTY;
        end
      end

      // Any accepted push not taken by the bypass goes to memory.
      if (push_acc && !(out_upd && mem_count == '0)) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end

      if (push_acc && !pop_acc) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  fifo_mem_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

endmodule
